// File: rtl/pp_loop_trace_unit_pkg.sv
// Shared types for the pipelined-loop tracer: event kinds, tracer FSM states
// and the event record carried through the event FIFO.
package pp_trace_pkg;

  localparam int TRACE_CNT_W      = 32;
  localparam int TRACE_TS_W       = 32;
  localparam int MAX_EV_PER_CYCLE = 2;

  typedef enum logic [1:0] {
    EV_LOOP_START = 2'd0,
    EV_ITER_START = 2'd1,
    EV_ITER_END   = 2'd2,
    EV_LOOP_END   = 2'd3
  } ev_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUN     = 2'd2,
    ST_STOPPED = 2'd3
  } trace_state_e;

  typedef struct packed {
    ev_kind_e                kind;
    logic [TRACE_CNT_W-1:0]  count;
    logic [TRACE_TS_W-1:0]   timestamp;
  } trace_event_t;

endpackage

// File: rtl/pp_loop_trace_unit_fifo.sv
// Two-write / one-read first-word-fall-through FIFO of trace events.
// The writer must never request more pushes than free_slots reports.
module trace_fifo_2w1r
  import pp_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 push_cnt,
  input  trace_event_t               wdata0,
  input  trace_event_t               wdata1,
  input  logic                       pop,
  output trace_event_t               rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     free_slots,
  output logic                       empty_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_event_t    mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            pop_ok;

  // A same-cycle pop hands its slot to this cycle's pushes.
  always_comb begin
    pop_ok     = pop && (count != {CW{1'b0}});
    free_slots = CW'(DEPTH) - count + CW'(pop_ok);
    count_nxt  = count + CW'(push_cnt) - CW'(pop_ok);
    empty_nxt  = (count_nxt == {CW{1'b0}});
    valid      = (count != {CW{1'b0}});
    rdata      = mem[rptr];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_cnt != 2'd0) mem[wptr] <= wdata0;
      if (push_cnt == 2'd2) mem[wptr + AW'(1)] <= wdata1;
      wptr  <= wptr + AW'(push_cnt);
      if (pop_ok) rptr <= rptr + AW'(1);
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/pp_loop_trace_unit.sv
// Tracer for one pipelined HLS loop: detects loop entry/exit and iteration
// issue/retire from the kernel FSM, timestamps them and queues them in a FIFO.
module pp_loop_trace_unit
  import pp_trace_pkg::*;
#(
  parameter int STATE_W    = 16,
  parameter int CNT_W      = TRACE_CNT_W,
  parameter int TS_W       = TRACE_TS_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] pre_loop_state0,
  input  logic [STATE_W-1:0] post_loop_state0,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic               iter_start_enable,
  input  logic               iter_start_block,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_end_enable,
  input  logic               iter_end_block,
  input  logic               finish,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [1:0]         ev_kind,
  output logic [CNT_W-1:0]   ev_count,
  output logic [TS_W-1:0]    ev_time,
  output logic               overflow,
  output logic [15:0]        drop_cnt,
  output logic               done
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  trace_state_e     state;
  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] act_cnt;
  logic [CNT_W-1:0] iss_cnt;
  logic [CNT_W-1:0] ret_cnt;

  logic             at_start;
  logic             loop_start;
  logic             loop_end;
  logic             run_body;
  logic             iter_s;
  logic             iter_e;
  logic [1:0]       n_ev;
  logic [1:0]       push_cnt;
  logic             accept;
  trace_event_t     wd0;
  trace_event_t     wd1;
  trace_event_t     head;
  logic [FW-1:0]    free_slots;
  logic             empty_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic trace_event_t mk_ev(input ev_kind_e k, input logic [CNT_W-1:0] c,
                                         input logic [TS_W-1:0] t);
    trace_event_t e;
    e.kind      = k;
    e.count     = TRACE_CNT_W'(c);
    e.timestamp = TRACE_TS_W'(t);
    return e;
  endfunction

  // Event detection and slot ordering: LOOP_START, then ITER_END, then ITER_START.
  always_comb begin
    at_start   = (cur_state == iter_start_state);
    loop_start = (state == ST_ARMED) && at_start;
    loop_end   = (state == ST_RUN) && (cur_state == post_loop_state0);
    run_body   = (state == ST_RUN) && !loop_end;
    iter_s     = (loop_start || run_body) && at_start && iter_start_enable && !iter_start_block;
    // Nothing can retire on the entry cycle, so ITER_END is only seen in RUN.
    iter_e     = run_body && (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
    n_ev       = 2'd0;
    wd0        = '0;
    wd1        = '0;
    if (loop_end) begin
      n_ev = 2'd1;
      wd0  = mk_ev(EV_LOOP_END, ret_cnt, ts);
    end else if (loop_start) begin
      wd0 = mk_ev(EV_LOOP_START, sat_inc(act_cnt), ts);
      wd1 = mk_ev(EV_ITER_START, {CNT_W{1'b0}}, ts);
      n_ev = iter_s ? 2'd2 : 2'd1;
    end else if (iter_e) begin
      wd0 = mk_ev(EV_ITER_END, ret_cnt, ts);
      wd1 = mk_ev(EV_ITER_START, iss_cnt, ts);
      n_ev = iter_s ? 2'd2 : 2'd1;
    end else if (iter_s) begin
      wd0  = mk_ev(EV_ITER_START, iss_cnt, ts);
      n_ev = 2'd1;
    end else begin
      n_ev = 2'd0;
    end
    accept   = (FW'(n_ev) <= free_slots);
    push_cnt = accept ? n_ev : 2'd0;
  end

  // Tracer FSM, timestamp and per-loop counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ts      <= '0;
      act_cnt <= '0;
      iss_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (finish) begin
        state <= ST_STOPPED;
      end else begin
        case (state)
          ST_IDLE:    if (cur_state == pre_loop_state0) state <= ST_ARMED;
          ST_ARMED: begin
            if (at_start) state <= ST_RUN;
            else if (cur_state != pre_loop_state0) state <= ST_IDLE;
          end
          ST_RUN:     if (loop_end) state <= ST_IDLE;
          ST_STOPPED: state <= ST_STOPPED;
          default:    state <= ST_IDLE;
        endcase
      end
      if (loop_start) begin
        act_cnt <= sat_inc(act_cnt);
        iss_cnt <= iter_s ? CNT_W'(1) : {CNT_W{1'b0}};
        ret_cnt <= '0;
      end else begin
        if (iter_s) iss_cnt <= sat_inc(iss_cnt);
        if (iter_e) ret_cnt <= sat_inc(ret_cnt);
      end
    end
  end

  // Drop accounting and completion flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
      done     <= 1'b0;
    end else begin
      if (!accept) begin
        overflow <= 1'b1;
        drop_cnt <= (drop_cnt > (16'hFFFF - 16'(n_ev))) ? 16'hFFFF : drop_cnt + 16'(n_ev);
      end
      done <= (finish || (state == ST_STOPPED)) && empty_nxt;
    end
  end

  trace_fifo_2w1r #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_cnt   (push_cnt),
    .wdata0     (wd0),
    .wdata1     (wd1),
    .pop        (ev_ready),
    .rdata      (head),
    .valid      (ev_valid),
    .free_slots (free_slots),
    .empty_nxt  (empty_nxt)
  );

  assign ev_kind  = head.kind;
  assign ev_count = CNT_W'(head.count);
  assign ev_time  = TS_W'(head.timestamp);

endmodule
